// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use interlock, branch
// flush and data-memory freeze, plus a saturating load-use stall counter.
module hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        ex_branch_taken,
  input  logic        dmem_busy,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic [15:0] lu_stall_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(2'b00);
  localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(2'b01);
  localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(2'b10);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [REG_W-1:0] REG_X0  = REG_W'(0);

  // Destination-side view of an in-flight instruction (EX and MEM stages).
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } dst_t;

  // WB entry: once a result is in WB it is forwardable whether or not it
  // came from a load, so load-ness is not carried into this stage.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } wb_t;

  // EX entry also keeps its source operands for the forwarding compare.
  typedef struct packed {
    dst_t             dst;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;
  } ex_t;

  localparam ex_t  EX_BUBBLE  = '0;
  localparam dst_t DST_BUBBLE = '0;
  localparam wb_t  WB_BUBBLE  = '0;

  ex_t              ex_q,  ex_d;
  dst_t             mem_q, mem_d;
  wb_t              wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_use;
  logic             ld_hit_rs1;
  logic             ld_hit_rs2;

  // Operand select for one EX source: MEM ALU result first, then WB result.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic             ex_valid,
    input logic [REG_W-1:0] rs,
    input logic             rs_used,
    input dst_t             mem,
    input wb_t              wb
  );
    logic src_live;
    logic mem_hit;
    logic wb_hit;
    src_live = ex_valid && rs_used && (rs != REG_X0);
    mem_hit  = src_live && mem.valid && mem.reg_write && !mem.mem_read &&
               (mem.rd == rs);
    wb_hit   = src_live && wb.valid && wb.reg_write && (wb.rd == rs);
    if (mem_hit) begin
      fwd_sel = FWD_MEM;
    end else if (wb_hit) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  endfunction

  // Load in EX feeding a source the decode instruction actually reads.
  always_comb begin
    ld_hit_rs1 = id_rs1_used && (id_rs1 == ex_q.dst.rd);
    ld_hit_rs2 = id_rs2_used && (id_rs2 == ex_q.dst.rd);
    load_use   = ex_q.dst.valid && ex_q.dst.mem_read &&
                 (ex_q.dst.rd != REG_X0) && id_valid &&
                 (ld_hit_rs1 || ld_hit_rs2);
  end

  // EX operand-mux selects.
  always_comb begin
    fwd_a_sel = fwd_sel(ex_q.dst.valid, ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
    fwd_b_sel = fwd_sel(ex_q.dst.valid, ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);
  end

  // Pipeline control; freeze beats branch, branch beats load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (dmem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (ex_branch_taken) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Tracker advance and stall counter next state; everything holds on freeze.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!dmem_busy) begin
      wb_d.valid     = mem_q.valid;
      wb_d.rd        = mem_q.rd;
      wb_d.reg_write = mem_q.reg_write;
      mem_d          = ex_q.dst;
      if (flush_e) begin
        ex_d = EX_BUBBLE;
      end else begin
        ex_d.dst.valid     = id_valid;
        ex_d.dst.rd        = id_rd;
        ex_d.dst.reg_write = id_reg_write;
        ex_d.dst.mem_read  = id_mem_read;
        ex_d.rs1           = id_rs1;
        ex_d.rs2           = id_rs2;
        ex_d.rs1_used      = id_rs1_used;
        ex_d.rs2_used      = id_rs2_used;
      end
      if (load_use && !ex_branch_taken && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Tracker and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= DST_BUBBLE;
      wb_q  <= WB_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign lu_stall_cnt = cnt_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameters: none; register index width fixed at 5; forward-select width fixed at 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_rs1, id_rs2  in  5 each  decode source register indices.
REQ-006 id_rs1_used, id_rs2_used  in  1 each  source actually read by the decode instruction.
REQ-007 id_rd  in  5  decode destination index; id_reg_write  in  1  writes rd; id_mem_read  in  1  is a load.
REQ-008 ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
REQ-009 dmem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-010 fwd_a_sel, fwd_b_sel  out  2 each  EX operand-mux selects: 00 regfile, 01 WB result, 10 MEM ALU result, 11 never driven.
REQ-011 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register.
REQ-012 flush_d, flush_e  out  1 each  load bubble into the corresponding pipeline register.
REQ-013 lu_stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-014 Internal tracker shall hold EX, MEM, WB entries: {valid, rd, reg_write, mem_read}; EX entry additionally holds rs1, rs2, rs1_used, rs2_used.
REQ-015 Outputs fwd_*, stall_*, flush_* shall be combinational from tracker state and current inputs; no added latency.
REQ-016 Forward A: if EX.rs1_used & EX.rs1!=0 & MEM.valid & MEM.reg_write & MEM.rd==EX.rs1 & !MEM.mem_read -> 10; else if same with WB (mem_read ignored) -> 01; else 00. Forward B identical on rs2.
REQ-017 MEM match takes priority over WB match; rd==0 shall never forward.
REQ-018 Load-use: EX.valid & EX.mem_read & EX.rd!=0 & id_valid & ((id_rs1_used & id_rs1==EX.rd) | (id_rs2_used & id_rs2==EX.rd)) -> stall_f=stall_d=1, flush_e=1.
REQ-019 Branch: ex_branch_taken -> flush_d=1, flush_e=1, stall_f=stall_d=0; overrides load-use.
REQ-020 Freeze: dmem_busy -> all four stall_* =1, both flush_* =0; overrides branch and load-use; tracker holds; counter holds.
REQ-021 stall_e and stall_m shall be 1 only during freeze.
REQ-022 Tracker advance when not frozen: WB<=MEM, MEM<=EX; EX<=invalid bubble if flush_e, else decode fields with valid=id_valid.
REQ-023 Decode entry captured into EX only when not stalled by load-use; during load-use the decode instruction is re-evaluated next cycle.
REQ-024 Invalid entries shall never match for forwarding or load-use.
REQ-025 lu_stall_cnt increments by 1 each non-frozen cycle with load-use asserted and branch not taken; saturates at 0xFFFF.
REQ-026 Forward select 11 shall never be produced under any input combination.

Reset
REQ-027 rst_n low shall immediately clear all tracker valid bits and lu_stall_cnt to 0, independent of clk.
REQ-028 During and after reset, until new entries arrive: fwd_a_sel=fwd_b_sel=00, all stall_*=0, all flush_*=0 unless driven by ex_branch_taken/dmem_busy inputs.
REQ-029 Reset asserted mid-stall shall drop the stall on the same asynchronous event; first post-reset edge captures decode normally.

Verification
REQ-030 ALU chain: add x5 enters EX, next cycle dependent rs1=5 in EX with add in MEM -> fwd_a_sel=10; one cycle later with add in WB and other instr in MEM not writing x5 -> fwd_a_sel=01.
REQ-031 Load-use: lw x7 in EX, decode rs2=7 used -> stall_f=stall_d=flush_e=1 for exactly one cycle, lu_stall_cnt 0->1; next cycle lw in MEM, no stall, then fwd_b_sel=01 when lw reaches WB.
REQ-032 x0: writer rd=0 reg_write=1 in MEM, EX rs1=0 used -> fwd_a_sel=00; load rd=0 in EX with decode rs1=0 -> no stall.
REQ-033 Priority: load-use condition and ex_branch_taken=1 same cycle -> flush_d=flush_e=1, stall_f=stall_d=0, counter unchanged; add dmem_busy=1 -> all stalls 1, flushes 0, tracker contents unchanged after edge.
REQ-034 Double match: MEM and WB both write x3, EX rs1=rs2=3 -> both selects 10.
REQ-035 Reset/saturation: preload counter to 0xFFFF via repeated load-use, one more -> stays 0xFFFF; assert rst_n=0 mid-stall -> counter 0, stall_f=0 without clock edge.
